// File: rtl/rr_mux_4_1_arbiter_pkg.sv
// Shared types and constants for the round-robin 4:1 mux front end.
// rr_next returns the first requesting channel after 'last' in rotation.
package mux_pkg;

   localparam int CH_N = 4;

   typedef logic [1:0] ch_idx_t;

   localparam ch_idx_t RST_LAST_GRANT = 2'd3;

   // Scan from farthest (last itself) to nearest (last+1) so the nearest requester wins.
   function automatic ch_idx_t rr_next(input logic [CH_N-1:0] req, input ch_idx_t last);
      ch_idx_t idx;
      rr_next = last;
      for (int k = CH_N; k >= 1; k--) begin
         idx = last + ch_idx_t'(k);
         if (req[idx]) rr_next = idx;
      end
   endfunction

endpackage

// File: rtl/rr_mux_4_1_arbiter_mux.sv
// Plain 4:1 data multiplexer; the arbiter drives its select.
module mux_4_1
   import mux_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] d0,
   input  logic [W-1:0] d1,
   input  logic [W-1:0] d2,
   input  logic [W-1:0] d3,
   input  ch_idx_t      sel,
   output logic [W-1:0] y
);

   always_comb begin
      y = d0;
      case (sel)
         2'd0: y = d0;
         2'd1: y = d1;
         2'd2: y = d2;
         2'd3: y = d3;
         default: y = d0;
      endcase
   end

endmodule

// File: rtl/rr_mux_4_1_arbiter.sv
// Four 1-entry producer buffers, round-robin pick into a 4:1 mux, and a
// registered valid/ready output slot.
module rr_mux_4_1_arbiter
   import mux_pkg::*;
#(
   parameter int W = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [CH_N-1:0] in_valid,
   input  logic [W-1:0]    in_data0,
   input  logic [W-1:0]    in_data1,
   input  logic [W-1:0]    in_data2,
   input  logic [W-1:0]    in_data3,
   output logic [CH_N-1:0] in_ready,
   output ch_idx_t         sel,
   output logic            out_valid,
   output logic [W-1:0]    out_data,
   input  logic            out_ready
);

   logic [CH_N-1:0]        hold_valid;
   logic [CH_N-1:0][W-1:0] hold_data;
   logic [CH_N-1:0][W-1:0] in_data_a;
   logic [CH_N-1:0]        fire;
   logic                   slot_free;
   logic                   grant;
   ch_idx_t                g;
   ch_idx_t                last_grant;
   logic [W-1:0]           mux_y;

   assign in_data_a = {in_data3, in_data2, in_data1, in_data0};

   // A full buffer is never ready, so a channel being granted cannot refill that cycle.
   assign in_ready  = {CH_N{rst_n}} & ~hold_valid;
   assign fire      = in_valid & in_ready;

   assign slot_free = ~out_valid | out_ready;
   assign grant     = slot_free & (|hold_valid);
   assign g         = rr_next(hold_valid, last_grant);
   assign sel       = grant ? g : last_grant;

   mux_4_1 #(.W(W)) u_mux (
      .d0  (hold_data[0]),
      .d1  (hold_data[1]),
      .d2  (hold_data[2]),
      .d3  (hold_data[3]),
      .sel (sel),
      .y   (mux_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_valid <= '0;
         hold_data  <= '0;
      end else begin
         for (int i = 0; i < CH_N; i++) begin
            if (grant && g == ch_idx_t'(i)) begin
               hold_valid[i] <= 1'b0;
            end else if (fire[i]) begin
               hold_valid[i] <= 1'b1;
               hold_data[i]  <= in_data_a[i];
            end
         end
      end
   end

   // A grant on a draining slot simply overwrites it, keeping out_valid high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         last_grant <= RST_LAST_GRANT;
      end else if (grant) begin
         out_valid  <= 1'b1;
         out_data   <= mux_y;
         last_grant <= g;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_mux_4_1_arbiter.sv
// Bench for rr_mux_4_1_arbiter: directed vector table, corner sequences,
// and random traffic against a rotation-order reference model.
module tb_rr_mux_4_1_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] in_valid;
   logic [3:0] in_data0, in_data1, in_data2, in_data3;
   logic [3:0] in_ready;
   logic [1:0] sel;
   logic       out_valid;
   logic [3:0] out_data;
   logic       out_ready;

   int checks = 0;
   int errors = 0;

   rr_mux_4_1_arbiter #(.W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data0  (in_data0),
      .in_data1  (in_data1),
      .in_data2  (in_data2),
      .in_data3  (in_data3),
      .in_ready  (in_ready),
      .sel       (sel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] iv;
      logic [15:0] din;
      logic       ordy;
      logic [3:0] rdy;
      logic       ov;
      logic [3:0] od;
      logic [1:0] sel;
   } vec_t;

   vec_t tbl[16];

   // Reference model: buffered words per channel, pointer of last winner, output slot.
   bit         mv[4];
   logic [3:0] md[4];
   int         mlast;
   bit         mov;
   logic [3:0] mod;
   int         gm;
   logic [1:0] gs;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic mreset();
      for (int i = 0; i < 4; i++) begin mv[i] = 0; md[i] = '0; end
      mlast = 3; mov = 0; mod = '0; gm = -1;
   endtask

   // One cycle: drive at posedge+1, check at negedge, advance model, return at posedge+1.
   task automatic step(input logic [3:0] iv, input logic [15:0] din, input logic ordy);
      logic [3:0] exp_rdy;
      logic [1:0] exp_sel;
      int g, c;
      in_valid = iv;
      {in_data3, in_data2, in_data1, in_data0} = din;
      out_ready = ordy;
      @(negedge clk);
      g = -1;
      exp_rdy = '0;
      if (rst_n) begin
         for (int i = 0; i < 4; i++) exp_rdy[i] = !mv[i];
         if (!mov || ordy)
            for (int k = 1; k <= 4; k++) begin
               c = (mlast + k) % 4;
               if (g < 0 && mv[c]) g = c;
            end
         exp_sel = (g >= 0) ? 2'(g) : 2'(mlast);
      end else begin
         exp_sel = 2'd3;
      end
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("sel", 32'(sel), 32'(exp_sel));
      chk("out_valid", 32'(out_valid), rst_n ? 32'(mov) : 32'd0);
      chk("out_data", 32'(out_data), rst_n ? 32'(mod) : 32'd0);
      gm = g;
      gs = sel;
      if (!rst_n) begin
         mreset();
      end else begin
         if (g >= 0) begin
            mov = 1; mod = md[g]; mv[g] = 0; mlast = g;
         end else if (ordy) begin
            mov = 0;
         end
         for (int i = 0; i < 4; i++)
            if (iv[i] && exp_rdy[i]) begin mv[i] = 1; md[i] = din[i*4 +: 4]; end
         gm = g;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(4'b0, 16'h0, 1'b0);
      step(4'b0, 16'h0, 1'b0);
      rst_n = 1'b1;
   endtask

   initial begin
      int q[$];
      rst_n = 1'b0; in_valid = '0; out_ready = 1'b0;
      {in_data3, in_data2, in_data1, in_data0} = '0;
      mreset();

      //           rst  iv       din        ordy  rdy      ov  od    sel
      tbl[0]  = '{1'b1, 4'b1111, 16'hFFFF, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd3};
      tbl[1]  = '{1'b0, 4'b0100, 16'h0A00, 1'b1, 4'b1111, 1'b0, 4'h0, 2'd3};
      tbl[2]  = '{1'b0, 4'b0000, 16'h0000, 1'b1, 4'b1011, 1'b0, 4'h0, 2'd2};
      tbl[3]  = '{1'b0, 4'b0000, 16'h0000, 1'b1, 4'b1111, 1'b1, 4'hA, 2'd2};
      tbl[4]  = '{1'b1, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd3};
      tbl[5]  = '{1'b0, 4'b1111, 16'h4321, 1'b1, 4'b1111, 1'b0, 4'h0, 2'd3};
      tbl[6]  = '{1'b0, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd0};
      tbl[7]  = '{1'b0, 4'b0000, 16'h0000, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd1};
      tbl[8]  = '{1'b0, 4'b0000, 16'h0000, 1'b1, 4'b0011, 1'b1, 4'h2, 2'd2};
      tbl[9]  = '{1'b0, 4'b0000, 16'h0000, 1'b1, 4'b0111, 1'b1, 4'h3, 2'd3};
      tbl[10] = '{1'b0, 4'b1111, 16'h4321, 1'b1, 4'b1111, 1'b1, 4'h4, 2'd3};
      tbl[11] = '{1'b0, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'h4, 2'd0};
      tbl[12] = '{1'b0, 4'b0000, 16'h0000, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd1};
      tbl[13] = '{1'b0, 4'b0000, 16'h0000, 1'b1, 4'b0011, 1'b1, 4'h2, 2'd2};
      tbl[14] = '{1'b0, 4'b0000, 16'h0000, 1'b1, 4'b0111, 1'b1, 4'h3, 2'd3};
      tbl[15] = '{1'b0, 4'b0000, 16'h0000, 1'b1, 4'b1111, 1'b1, 4'h4, 2'd3};

      repeat (2) @(posedge clk);
      #1;
      for (int r = 0; r < 16; r++) begin
         rst_n     = !tbl[r].rst;
         in_valid  = tbl[r].iv;
         {in_data3, in_data2, in_data1, in_data0} = tbl[r].din;
         out_ready = tbl[r].ordy;
         @(negedge clk);
         chk($sformatf("tbl%0d_in_ready", r), 32'(in_ready), 32'(tbl[r].rdy));
         chk($sformatf("tbl%0d_out_valid", r), 32'(out_valid), 32'(tbl[r].ov));
         chk($sformatf("tbl%0d_out_data", r), 32'(out_data), 32'(tbl[r].od));
         chk($sformatf("tbl%0d_sel", r), 32'(sel), 32'(tbl[r].sel));
         @(posedge clk);
         #1;
      end

      // Backpressure: ch0 word parks in the slot, ch1 waits until out_ready rises.
      do_reset();
      step(4'b0011, 16'h0065, 1'b0);
      step(4'b0000, 16'h0000, 1'b0);
      repeat (5) begin
         step(4'b0000, 16'h0000, 1'b0);
         chk("bp_data", 32'(out_data), 32'h5);
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_hold", 32'(in_ready), 32'b1101);
      end
      step(4'b0000, 16'h0000, 1'b1);
      chk("bp_grant_sel", 32'(gs), 32'd1);
      chk("bp_next_data", 32'(out_data), 32'h6);
      chk("bp_next_valid", 32'(out_valid), 32'd1);

      // Fairness: ch0 and ch3 always requesting must alternate.
      do_reset();
      for (int n = 0; n < 16; n++) begin
         step(4'b1001, 16'h7007, 1'b1);
         if (gm >= 0) q.push_back(int'(gs));
      end
      chk("fair_count", 32'(q.size() >= 8), 32'd1);
      for (int n = 1; n < q.size(); n++) begin
         chk("fair_member", 32'(q[n] == 0 || q[n] == 3), 32'd1);
         chk("fair_alternate", 32'(q[n] != q[n-1]), 32'd1);
      end

      // Asynchronous reset with the slot full and three buffers loaded.
      do_reset();
      step(4'b0111, 16'h0987, 1'b0);
      step(4'b0000, 16'h0000, 1'b0);
      step(4'b0001, 16'h000B, 1'b0);
      chk("ar_pre_valid", 32'(out_valid), 32'd1);
      chk("ar_pre_ready", 32'(in_ready), 32'b1000);
      in_valid = '0;
      #1 rst_n = 1'b0;
      #1;
      chk("ar_out_valid", 32'(out_valid), 32'd0);
      chk("ar_out_data", 32'(out_data), 32'd0);
      chk("ar_in_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b1;
      mreset();
      #1;
      chk("ar_holds_empty", 32'(in_ready), 32'b1111);
      step(4'b0110, 16'h0CD0, 1'b1);
      step(4'b0000, 16'h0000, 1'b1);
      chk("ar_first_sel", 32'(gs), 32'd1);
      chk("ar_first_data", 32'(out_data), 32'hD);

      // Random traffic against the model.
      do_reset();
      for (int n = 0; n < 400; n++)
         step(4'($urandom), 16'($urandom), ($urandom % 4) != 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
